// File: rtl/alu_muldiv.sv
// -----------------------------------------------------------------------------
// alu_muldiv
//   Execute unit for RV32IM. Base integer ALU operations return a registered
//   result one cycle after acceptance, and a new one can be accepted every
//   cycle. M-extension operations run on an iterative shift-add multiplier or
//   a restoring divider. Both take DW iterations plus a DONE cycle.
//
// Ports
//   clk_i / rst       : rising-edge clock, synchronous active-high reset
//   valid_i, ready_o  : request handshake; accepted on valid_i & ready_o
//   opcode_i, func3_i : instruction decode fields
//   func7_5_i         : sub/sra select
//   func7_0_i         : M-extension select (opcode 0x33 only)
//   alu_operand_1_i   : rs1 / PC
//   alu_operand_2_i   : rs2 / immediate
//   alu_result_o      : registered result, held between valid_o pulses
//   zero_o            : registered (operand_1 == operand_2) at acceptance
//   valid_o           : one-cycle result strobe
//   busy_o            : multiply/divide iterations in progress
// -----------------------------------------------------------------------------
module alu_muldiv #(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          valid_i,
   output logic          ready_o,
   input  logic [6:0]    opcode_i,
   input  logic [2:0]    func3_i,
   input  logic          func7_5_i,
   input  logic          func7_0_i,
   input  logic [DW-1:0] alu_operand_1_i,
   input  logic [DW-1:0] alu_operand_2_i,
   output logic [DW-1:0] alu_result_o,
   output logic          zero_o,
   output logic          valid_o,
   output logic          busy_o
);

   localparam int SHW = $clog2(DW);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_DIV  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam logic [SHW-1:0] CNT_LAST = SHW'(DW - 1);

   // Registered state
   logic [1:0]      state_q, state_d;
   logic [SHW-1:0]  cnt_q,   cnt_d;
   logic [2*DW-1:0] acc_q,   acc_d;    // {partial product | multiplier} or {remainder | quotient}
   logic [DW-1:0]   opb_q,   opb_d;    // multiplicand or divisor magnitude
   logic [1:0]      f3_q,    f3_d;     // result select for DONE
   logic            neg_q,   neg_d;    // negate the final result
   logic [DW-1:0]   res_q,   res_d;
   logic            zero_q,  zero_d;
   logic            valid_q, valid_d;

   // Combinational helpers
   logic                 accept_s;
   logic                 is_m_s;
   logic [SHW-1:0]       shamt_s;
   logic signed [DW-1:0] sra_s;
   logic                 alu_sub_s;
   logic [DW-1:0]        rtype_res_s;
   logic [DW-1:0]        base_res_s;
   logic                 op1_signed_s, op2_signed_s;
   logic                 neg_a_s, neg_b_s;
   logic [DW-1:0]        mag_a_s, mag_b_s;
   logic                 m_neg_s;
   logic [DW:0]          mul_sum_s;
   logic [2*DW-1:0]      mul_next_s;
   logic                 div_ok_s;
   logic [DW-1:0]        div_diff_s;
   logic [2*DW-1:0]      div_next_s;
   logic [2*DW-1:0]      prod_s;
   logic [DW-1:0]        mul_res_s;
   logic [DW-1:0]        div_sel_s;
   logic [DW-1:0]        div_res_s;

   assign accept_s = valid_i & (state_q == ST_IDLE);
   assign is_m_s   = (opcode_i == 7'h33) & func7_0_i;

   // Base integer ALU result, computed directly from the request inputs
   always_comb begin
      shamt_s     = alu_operand_2_i[SHW-1:0];
      sra_s       = $signed(alu_operand_1_i) >>> shamt_s;
      // Only R-type uses func7_5 to pick SUB; ADDI always adds
      alu_sub_s   = (opcode_i == 7'h33) & func7_5_i;
      rtype_res_s = {DW{1'b0}};
      case (func3_i)
         3'b000:  rtype_res_s = alu_sub_s ? (alu_operand_1_i - alu_operand_2_i)
                                          : (alu_operand_1_i + alu_operand_2_i);
         3'b001:  rtype_res_s = alu_operand_1_i << shamt_s;
         3'b010:  rtype_res_s = {{(DW-1){1'b0}},
                                 ($signed(alu_operand_1_i) < $signed(alu_operand_2_i))};
         3'b011:  rtype_res_s = {{(DW-1){1'b0}}, (alu_operand_1_i < alu_operand_2_i)};
         3'b100:  rtype_res_s = alu_operand_1_i ^ alu_operand_2_i;
         3'b101:  rtype_res_s = func7_5_i ? DW'(sra_s) : (alu_operand_1_i >> shamt_s);
         3'b110:  rtype_res_s = alu_operand_1_i | alu_operand_2_i;
         3'b111:  rtype_res_s = alu_operand_1_i & alu_operand_2_i;
         default: rtype_res_s = {DW{1'b0}};
      endcase

      case (opcode_i)
         7'h33, 7'h13:                      base_res_s = rtype_res_s;
         // Loads, stores, branches, AUIPC, LUI, JALR and JAL all need operand_1 + operand_2
         7'h03, 7'h23, 7'h63, 7'h17,
         7'h37, 7'h67, 7'h6F:               base_res_s = alu_operand_1_i + alu_operand_2_i;
         default:                           base_res_s = {DW{1'b0}};
      endcase
   end

   // Operand sign handling for M ops: iterate on magnitudes, fix the sign at the end
   always_comb begin
      op1_signed_s = (func3_i == 3'b001) | (func3_i == 3'b010) |
                     (func3_i == 3'b100) | (func3_i == 3'b110);
      op2_signed_s = (func3_i == 3'b001) | (func3_i == 3'b100) | (func3_i == 3'b110);
      neg_a_s      = op1_signed_s & alu_operand_1_i[DW-1];
      neg_b_s      = op2_signed_s & alu_operand_2_i[DW-1];
      mag_a_s      = neg_a_s ? (-alu_operand_1_i) : alu_operand_1_i;
      mag_b_s      = neg_b_s ? (-alu_operand_2_i) : alu_operand_2_i;
      case (func3_i[2:1])
         2'b00, 2'b01: m_neg_s = neg_a_s ^ neg_b_s;
         // A zero divisor must leave the all-ones quotient untouched
         2'b10:        m_neg_s = (neg_a_s ^ neg_b_s) & (alu_operand_2_i != {DW{1'b0}});
         2'b11:        m_neg_s = neg_a_s;      // remainder follows the dividend
         default:      m_neg_s = 1'b0;
      endcase
   end

   // One multiply step and one restoring-divide step on the current accumulator
   always_comb begin
      // Multiply: add the multiplicand to the upper half when the multiplier LSB is set, then shift right
      mul_sum_s  = {1'b0, acc_q[2*DW-1:DW]} + (acc_q[0] ? {1'b0, opb_q} : {(DW+1){1'b0}});
      mul_next_s = {mul_sum_s, acc_q[DW-1:1]};

      // Divide: shift the next dividend bit into the remainder and subtract if it fits.
      // A zero divisor always fits, so the quotient becomes all ones and the remainder becomes the dividend.
      div_ok_s   = {acc_q[2*DW-1:DW], acc_q[DW-1]} >= {1'b0, opb_q};
      div_diff_s = {acc_q[2*DW-2:DW], acc_q[DW-1]} - opb_q;
      div_next_s = div_ok_s ? {div_diff_s, acc_q[DW-2:0], 1'b1}
                            : {acc_q[2*DW-2:0], 1'b0};
   end

   // Signed final results taken from the last iteration's accumulator
   always_comb begin
      prod_s    = neg_q ? (-mul_next_s) : mul_next_s;
      mul_res_s = (f3_q == 2'b00) ? prod_s[DW-1:0] : prod_s[2*DW-1:DW];
      div_sel_s = f3_q[1] ? div_next_s[2*DW-1:DW] : div_next_s[DW-1:0];
      div_res_s = neg_q ? (-div_sel_s) : div_sel_s;
   end

   // Next-state logic for the sequencer and output registers
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      opb_d   = opb_q;
      f3_d    = f3_q;
      neg_d   = neg_q;
      res_d   = res_q;
      zero_d  = zero_q;
      valid_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               zero_d = (alu_operand_1_i == alu_operand_2_i);
               if (is_m_s) begin
                  f3_d  = func3_i[1:0];
                  neg_d = m_neg_s;
                  cnt_d = {SHW{1'b0}};
                  if (func3_i[2]) begin
                     acc_d   = {{DW{1'b0}}, mag_a_s};   // dividend
                     opb_d   = mag_b_s;                 // divisor
                     state_d = ST_DIV;
                  end else begin
                     acc_d   = {{DW{1'b0}}, mag_b_s};   // multiplier
                     opb_d   = mag_a_s;                 // multiplicand
                     state_d = ST_MUL;
                  end
               end else begin
                  res_d   = base_res_s;
                  valid_d = 1'b1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_MUL: begin
            acc_d = mul_next_s;
            if (cnt_q == CNT_LAST) begin
               cnt_d   = {SHW{1'b0}};
               res_d   = mul_res_s;
               valid_d = 1'b1;
               state_d = ST_DONE;
            end else begin
               cnt_d   = cnt_q + 1'b1;
            end
         end
         ST_DIV: begin
            acc_d = div_next_s;
            if (cnt_q == CNT_LAST) begin
               cnt_d   = {SHW{1'b0}};
               res_d   = div_res_s;
               valid_d = 1'b1;
               state_d = ST_DONE;
            end else begin
               cnt_d   = cnt_q + 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= {SHW{1'b0}};
         acc_q   <= {(2*DW){1'b0}};
         opb_q   <= {DW{1'b0}};
         f3_q    <= 2'b00;
         neg_q   <= 1'b0;
         res_q   <= {DW{1'b0}};
         zero_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         opb_q   <= opb_d;
         f3_q    <= f3_d;
         neg_q   <= neg_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
         valid_q <= valid_d;
      end
   end

   assign ready_o      = (state_q == ST_IDLE);
   assign busy_o       = (state_q == ST_MUL) | (state_q == ST_DIV);
   assign alu_result_o = res_q;
   assign zero_o       = zero_q;
   assign valid_o      = valid_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// -----------------------------------------------------------------------------
// tb_alu_muldiv
//   Directed self-checking bench for alu_muldiv (DW = 32). Inputs change 1 ns
//   after a rising edge, and outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_alu_muldiv;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          valid_i;
   logic          ready_o;
   logic [6:0]    opcode_i;
   logic [2:0]    func3_i;
   logic          func7_5_i;
   logic          func7_0_i;
   logic [DW-1:0] alu_operand_1_i;
   logic [DW-1:0] alu_operand_2_i;
   logic [DW-1:0] alu_result_o;
   logic          zero_o;
   logic          valid_o;
   logic          busy_o;

   int cmp_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   alu_muldiv #(.DW(DW)) dut (
      .clk             (clk),
      .rst             (rst),
      .valid_i         (valid_i),
      .ready_o         (ready_o),
      .opcode_i        (opcode_i),
      .func3_i         (func3_i),
      .func7_5_i       (func7_5_i),
      .func7_0_i       (func7_0_i),
      .alu_operand_1_i (alu_operand_1_i),
      .alu_operand_2_i (alu_operand_2_i),
      .alu_result_o    (alu_result_o),
      .zero_o          (zero_o),
      .valid_o         (valid_o),
      .busy_o          (busy_o)
   );

   task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                        input logic f70, input logic [31:0] a, input logic [31:0] b);
      opcode_i        = op;
      func3_i         = f3;
      func7_5_i       = f75;
      func7_0_i       = f70;
      alu_operand_1_i = a;
      alu_operand_2_i = b;
      valid_i         = 1'b1;
   endtask

   // Issue one M op and wait (bounded) for its result; lat counts cycles after acceptance
   task automatic run_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res, output logic zr,
                        output logic busy1);
      drive(7'h33, f3, 1'b0, 1'b1, a, b);
      @(posedge clk); #1;
      valid_i = 1'b0;
      lat     = 1;
      busy1   = busy_o;
      while (valid_o !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      res = alu_result_o;
      zr  = zero_o;
      @(posedge clk); #1;   // DONE -> IDLE
   endtask

   task automatic test_reset;
      rst = 1'b1;
      valid_i = 1'b0;
      drive(7'h00, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
      valid_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      cmp_cnt++; if (alu_result_o !== 32'h0) begin err_cnt++; $display("FAIL reset_result: got %h want %h", alu_result_o, 32'h0); end
      cmp_cnt++; if (zero_o !== 1'b0)  begin err_cnt++; $display("FAIL reset_zero: got %b want 0", zero_o); end
      cmp_cnt++; if (valid_o !== 1'b0) begin err_cnt++; $display("FAIL reset_valid: got %b want 0", valid_o); end
      cmp_cnt++; if (busy_o !== 1'b0)  begin err_cnt++; $display("FAIL reset_busy: got %b want 0", busy_o); end
      cmp_cnt++; if (ready_o !== 1'b1) begin err_cnt++; $display("FAIL reset_ready: got %b want 1", ready_o); end
   endtask

   task automatic test_back_to_back;
      drive(7'h33, 3'b000, 1'b0, 1'b0, 32'd5, 32'd7);          // ADD
      @(posedge clk); #1;
      cmp_cnt++; if (valid_o !== 1'b1) begin err_cnt++; $display("FAIL b2b_add_valid: got %b want 1", valid_o); end
      cmp_cnt++; if (alu_result_o !== 32'h0000000C) begin err_cnt++; $display("FAIL b2b_add: got %h want %h", alu_result_o, 32'h0000000C); end
      cmp_cnt++; if (ready_o !== 1'b1) begin err_cnt++; $display("FAIL b2b_ready1: got %b want 1", ready_o); end
      drive(7'h33, 3'b000, 1'b1, 1'b0, 32'd5, 32'd7);          // SUB
      @(posedge clk); #1;
      valid_i = 1'b0;
      cmp_cnt++; if (valid_o !== 1'b1) begin err_cnt++; $display("FAIL b2b_sub_valid: got %b want 1", valid_o); end
      cmp_cnt++; if (alu_result_o !== 32'hFFFFFFFE) begin err_cnt++; $display("FAIL b2b_sub: got %h want %h", alu_result_o, 32'hFFFFFFFE); end
      cmp_cnt++; if (ready_o !== 1'b1) begin err_cnt++; $display("FAIL b2b_ready2: got %b want 1", ready_o); end
      @(posedge clk); #1;
      cmp_cnt++; if (valid_o !== 1'b0) begin err_cnt++; $display("FAIL b2b_pulse_end: got %b want 0", valid_o); end
      cmp_cnt++; if (alu_result_o !== 32'hFFFFFFFE) begin err_cnt++; $display("FAIL b2b_hold: got %h want %h", alu_result_o, 32'hFFFFFFFE); end
   endtask

   task automatic test_base_ops;
      logic [6:0]  op  [10] = '{7'h13, 7'h13, 7'h33, 7'h33, 7'h33, 7'h13, 7'h37, 7'h7F, 7'h13, 7'h33};
      logic [2:0]  f3  [10] = '{3'b101, 3'b010, 3'b011, 3'b101, 3'b100, 3'b000, 3'b000, 3'b000, 3'b001, 3'b111};
      logic        f75 [10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [31:0] a   [10] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hA5A5A5A5,
                                32'h00000010, 32'h12345000, 32'h00000003, 32'h00000001, 32'hF0F0F0F0};
      logic [31:0] b   [10] = '{32'h00000424, 32'h00000001, 32'h00000001, 32'h00000024, 32'hA5A5A5A5,
                                32'h00000003, 32'h00000001, 32'h00000003, 32'h0000001F, 32'h3C3C3C3C};
      logic [31:0] exp [10] = '{32'hF8000000, 32'h00000001, 32'h00000000, 32'h08000000, 32'h00000000,
                                32'h00000013, 32'h12345001, 32'h00000000, 32'h80000000, 32'h30303030};
      logic        ez  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 10; i++) begin
         drive(op[i], f3[i], f75[i], 1'b0, a[i], b[i]);
         @(posedge clk); #1;
         valid_i = 1'b0;
         cmp_cnt++; if (valid_o !== 1'b1) begin err_cnt++; $display("FAIL base%0d_valid: got %b want 1", i, valid_o); end
         cmp_cnt++; if (alu_result_o !== exp[i]) begin err_cnt++; $display("FAIL base%0d_result: got %h want %h", i, alu_result_o, exp[i]); end
         cmp_cnt++; if (zero_o !== ez[i]) begin err_cnt++; $display("FAIL base%0d_zero: got %b want %b", i, zero_o, ez[i]); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_mul;
      logic [2:0]  f3  [4] = '{3'b001, 3'b010, 3'b000, 3'b011};
      logic [31:0] a   [4] = '{32'h80000000, 32'hFFFFFFFF, 32'h00000007, 32'hFFFFFFFF};
      logic [31:0] b   [4] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF};
      logic [31:0] exp [4] = '{32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFEB, 32'hFFFFFFFE};
      logic [31:0] res;
      logic        zr, b1;
      int          lat;
      for (int i = 0; i < 4; i++) begin
         run_m(f3[i], a[i], b[i], lat, res, zr, b1);
         cmp_cnt++; if (lat != 33) begin err_cnt++; $display("FAIL mul%0d_latency: got %0d want 33", i, lat); end
         cmp_cnt++; if (res !== exp[i]) begin err_cnt++; $display("FAIL mul%0d_result: got %h want %h", i, res, exp[i]); end
         cmp_cnt++; if (b1 !== 1'b1) begin err_cnt++; $display("FAIL mul%0d_busy: got %b want 1", i, b1); end
         if (i == 0) begin
            cmp_cnt++; if (zr !== 1'b1) begin err_cnt++; $display("FAIL mulh_zero: got %b want 1", zr); end
         end
      end
   endtask

   task automatic test_div;
      logic [2:0]  f3  [6] = '{3'b100, 3'b110, 3'b101, 3'b110, 3'b100, 3'b110};
      logic [31:0] a   [6] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'h00000007, 32'h00000007, 32'h80000000, 32'h80000000};
      logic [31:0] b   [6] = '{32'h00000002, 32'h00000002, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
      logic [31:0] exp [6] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000007, 32'h80000000, 32'h00000000};
      logic [31:0] res;
      logic        zr, b1;
      int          lat;
      for (int i = 0; i < 6; i++) begin
         run_m(f3[i], a[i], b[i], lat, res, zr, b1);
         cmp_cnt++; if (lat != 33) begin err_cnt++; $display("FAIL div%0d_latency: got %0d want 33", i, lat); end
         cmp_cnt++; if (res !== exp[i]) begin err_cnt++; $display("FAIL div%0d_result: got %h want %h", i, res, exp[i]); end
      end
   endtask

   task automatic test_valid_held;
      int lat;
      drive(7'h33, 3'b100, 1'b0, 1'b1, 32'd100, 32'd7);        // DIV 100/7 = 14
      @(posedge clk); #1;
      // Keep requesting an ADD; it must wait for ready_o
      drive(7'h33, 3'b000, 1'b0, 1'b0, 32'd1, 32'd2);
      lat = 1;
      while (valid_o !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      cmp_cnt++; if (lat != 33) begin err_cnt++; $display("FAIL held_div_latency: got %0d want 33", lat); end
      cmp_cnt++; if (alu_result_o !== 32'd14) begin err_cnt++; $display("FAIL held_div_result: got %h want %h", alu_result_o, 32'd14); end
      cmp_cnt++; if (ready_o !== 1'b0) begin err_cnt++; $display("FAIL held_done_ready: got %b want 0", ready_o); end
      @(posedge clk); #1;
      cmp_cnt++; if (ready_o !== 1'b1) begin err_cnt++; $display("FAIL held_ready_back: got %b want 1", ready_o); end
      cmp_cnt++; if (valid_o !== 1'b0) begin err_cnt++; $display("FAIL held_no_early_valid: got %b want 0", valid_o); end
      @(posedge clk); #1;
      valid_i = 1'b0;
      cmp_cnt++; if (valid_o !== 1'b1) begin err_cnt++; $display("FAIL held_add_valid: got %b want 1", valid_o); end
      cmp_cnt++; if (alu_result_o !== 32'd3) begin err_cnt++; $display("FAIL held_add_result: got %h want %h", alu_result_o, 32'd3); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid;
      int pulses;
      drive(7'h33, 3'b000, 1'b0, 1'b1, 32'd5, 32'd5);          // MUL, zero would capture 1
      @(posedge clk); #1;
      valid_i = 1'b0;
      repeat (9) begin
         @(posedge clk); #1;
      end
      cmp_cnt++; if (busy_o !== 1'b1) begin err_cnt++; $display("FAIL rmid_busy_before: got %b want 1", busy_o); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      cmp_cnt++; if (alu_result_o !== 32'h0) begin err_cnt++; $display("FAIL rmid_result: got %h want %h", alu_result_o, 32'h0); end
      cmp_cnt++; if (zero_o !== 1'b0)  begin err_cnt++; $display("FAIL rmid_zero: got %b want 0", zero_o); end
      cmp_cnt++; if (valid_o !== 1'b0) begin err_cnt++; $display("FAIL rmid_valid: got %b want 0", valid_o); end
      cmp_cnt++; if (busy_o !== 1'b0)  begin err_cnt++; $display("FAIL rmid_busy: got %b want 0", busy_o); end
      cmp_cnt++; if (ready_o !== 1'b1) begin err_cnt++; $display("FAIL rmid_ready: got %b want 1", ready_o); end
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (valid_o === 1'b1) pulses++;
      end
      cmp_cnt++; if (pulses != 0) begin err_cnt++; $display("FAIL rmid_stray_valid: got %0d pulses want 0", pulses); end
      drive(7'h33, 3'b000, 1'b0, 1'b0, 32'd1, 32'd1);
      @(posedge clk); #1;
      valid_i = 1'b0;
      cmp_cnt++; if (valid_o !== 1'b1) begin err_cnt++; $display("FAIL rmid_add_valid: got %b want 1", valid_o); end
      cmp_cnt++; if (alu_result_o !== 32'd2) begin err_cnt++; $display("FAIL rmid_add_result: got %h want %h", alu_result_o, 32'd2); end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_base_ops();
      test_mul();
      test_div();
      test_valid_held();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
